// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider with per-channel period tick.
// Optional CLKDIV_SYNC_EN adds sync_n to phase-align every channel.
module clock_divider_multi #(
   parameter int CHANNELS        = 2,
   parameter int WIDTH           = 28,
   parameter int DEFAULT_DIVISOR = 50000,
   parameter int SEL_W           = 1
) (
   input  logic                clock_in,
   input  logic                reset_n,
   input  logic                enable,
`ifdef CLKDIV_SYNC_EN
   input  logic                sync_n,
`endif
   input  logic                div_wr,
   input  logic [SEL_W-1:0]    div_sel,
   input  logic [WIDTH-1:0]    div_data,
   output logic [CHANNELS-1:0] div_pending,
   output logic [CHANNELS-1:0] clock_out,
   output logic [CHANNELS-1:0] tick
);

   localparam logic [WIDTH-1:0] DEF_D = WIDTH'(DEFAULT_DIVISOR);
   localparam logic [WIDTH-1:0] MIN_D = WIDTH'(2);

   logic [WIDTH-1:0] wr_val;
   logic             sync;

   assign wr_val = (div_data < MIN_D) ? MIN_D : div_data;

`ifdef CLKDIV_SYNC_EN
   assign sync = ~sync_n;
`else
   assign sync = 1'b0;
`endif

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic [WIDTH-1:0] cnt_q, cnt_d;
      logic [WIDTH-1:0] div_q, div_d;
      logic [WIDTH-1:0] pnd_q, pnd_d;
      logic [WIDTH-1:0] half;
      logic             pbit_q, pbit_d;
      logic             clk_q, clk_d;
      logic             tick_q, tick_d;
      logic             hit, last, wrap, apply;

      assign hit   = div_wr && (div_sel == SEL_W'(i));
      assign last  = (cnt_q == div_q - WIDTH'(1));
      assign wrap  = enable && last;
      assign apply = sync || wrap;

      always_comb begin
         cnt_d = cnt_q;
         div_d = div_q;
         if (apply) begin
            cnt_d = '0;
            if (pbit_q)
               div_d = pnd_q;
         end else if (enable) begin
            cnt_d = cnt_q + WIDTH'(1);
         end
      end

      // A write always lands in the pending slot, even on an apply edge.
      always_comb begin
         pnd_d  = pnd_q;
         pbit_d = pbit_q;
         if (hit) begin
            pnd_d  = wr_val;
            pbit_d = 1'b1;
         end else if (apply) begin
            pbit_d = 1'b0;
         end
      end

      // High phase starts at ceil(D/2), computed without overflow.
      always_comb begin
         half   = (div_d >> 1) + WIDTH'(div_d[0]);
         clk_d  = (cnt_d >= half);
         tick_d = wrap && !sync;
      end

      always_ff @(posedge clock_in or negedge reset_n) begin
         if (!reset_n) begin
            cnt_q  <= '0;
            div_q  <= DEF_D;
            pnd_q  <= DEF_D;
            pbit_q <= 1'b0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
         end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            pnd_q  <= pnd_d;
            pbit_q <= pbit_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
         end
      end

      assign div_pending[i] = pbit_q;
      assign clock_out[i]   = clk_q;
      assign tick[i]        = tick_q;
   end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Directed bench for clock_divider_multi, two channels, default divisor 4.
// Phase-align checks run only when CLKDIV_SYNC_EN is defined.
module tb_clock_divider_multi;
   localparam int CH = 2;
   localparam int W  = 8;
   localparam int DD = 4;
   localparam int SW = 2;

   logic          clock_in = 1'b0;
   logic          reset_n;
   logic          enable;
   logic          div_wr;
   logic [SW-1:0] div_sel;
   logic [W-1:0]  div_data;
   logic [CH-1:0] div_pending;
   logic [CH-1:0] clock_out;
   logic [CH-1:0] tick;
`ifdef CLKDIV_SYNC_EN
   logic          sync_n;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   int n;

   always #5 clock_in = ~clock_in;

   clock_divider_multi #(
      .CHANNELS(CH), .WIDTH(W), .DEFAULT_DIVISOR(DD), .SEL_W(SW)
   ) dut (
      .clock_in(clock_in),
      .reset_n(reset_n),
      .enable(enable),
`ifdef CLKDIV_SYNC_EN
      .sync_n(sync_n),
`endif
      .div_wr(div_wr),
      .div_sel(div_sel),
      .div_data(div_data),
      .div_pending(div_pending),
      .clock_out(clock_out),
      .tick(tick)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock_in);
      #1;
   endtask

   task automatic seq(input string tag, input int ch, input int len,
                      input logic [15:0] ov, input logic [15:0] tv);
      for (int k = 0; k < len; k++) begin
         step();
         chk({tag, "_clk"}, 32'(clock_out[ch]), 32'(ov[len-1-k]));
         chk({tag, "_tick"}, 32'(tick[ch]), 32'(tv[len-1-k]));
      end
   endtask

   task automatic wr(input logic [SW-1:0] sel, input logic [W-1:0] d);
      div_wr   = 1'b1;
      div_sel  = sel;
      div_data = d;
      step();
      div_wr   = 1'b0;
   endtask

   task automatic wait_tick(input int ch, input int maxc, output int cnt);
      cnt = -1;
      for (int k = 1; k <= maxc; k++) begin
         step();
         if (tick[ch]) begin
            cnt = k;
            break;
         end
      end
   endtask

   initial begin
      reset_n  = 1'b0;
      enable   = 1'b0;
      div_wr   = 1'b0;
      div_sel  = '0;
      div_data = '0;
`ifdef CLKDIV_SYNC_EN
      sync_n   = 1'b1;
`endif
      repeat (2) step();
      chk("rst_clk", 32'(clock_out), 32'h0);
      chk("rst_tick", 32'(tick), 32'h0);
      chk("rst_pend", 32'(div_pending), 32'h0);

      // default divisor 4
      reset_n = 1'b1;
      enable  = 1'b1;
      seq("def", 0, 8, 16'b01100110, 16'b00010001);

      // channel 1 -> 5, written mid-period
      step();
      wr(1, 5);
      chk("b_pend1", 32'(div_pending), 32'h2);
      step();
      chk("b_pend2", 32'(div_pending), 32'h2);
      step();
      chk("b_pend3", 32'(div_pending), 32'h0);
      chk("b_tick", 32'(tick), 32'h3);
      seq("d5", 1, 10, 16'b0011000110, 16'b0000100001);
      chk("b_ch0", 32'(clock_out), 32'h1);

      // 6 then 8 within one period: only 8 applies
      step();
      step();
      wr(0, 6);
      wr(0, 8);
      chk("c_pend1", 32'(div_pending), 32'h1);
      step();
      chk("c_pend2", 32'(div_pending), 32'h1);
      step();
      chk("c_pend3", 32'(div_pending), 32'h0);
      chk("c_tick", 32'(tick), 32'h1);
      seq("d8", 0, 8, 16'b00011110, 16'b00000001);
      chk("c_pend4", 32'(div_pending), 32'h0);

      // enable low for 7 cycles at c0 = 2
      step();
      step();
      enable = 1'b0;
      for (int k = 0; k < 7; k++) begin
         step();
         chk("hold_clk", 32'(clock_out), 32'h0);
         chk("hold_tick", 32'(tick), 32'h0);
      end
      enable = 1'b1;
      wait_tick(0, 20, n);
      chk("resume_gap", 32'(n), 32'd6);

      // clamp 0 -> 2 on channel 0
      wr(0, 0);
      chk("e_pend0", 32'(div_pending), 32'h1);
      wait_tick(0, 20, n);
      chk("e_gap0", 32'(n), 32'd7);
      chk("e_clr0", 32'(div_pending), 32'h0);
      seq("d2a", 0, 6, 16'b101010, 16'b010101);

      // clamp 1 -> 2 on channel 1
      wr(1, 1);
      chk("e_pend1", 32'(div_pending), 32'h2);
      wait_tick(1, 20, n);
      chk("e_gap1", 32'(n), 32'd3);
      chk("e_clr1", 32'(div_pending), 32'h0);
      seq("d2b", 1, 4, 16'b1010, 16'b0101);

      // out-of-range select ignored
      wr(2, 9);
      chk("f_pend", 32'(div_pending), 32'h0);
      chk("f_clk", 32'(clock_out), 32'h3);

      // write on the wrap edge of channel 0
      wr(0, 6);
      chk("g_pend1", 32'(div_pending), 32'h1);
      chk("g_tick1", 32'(tick), 32'h3);
      step();
      chk("g_pend2", 32'(div_pending), 32'h1);
      chk("g_clk", 32'(clock_out[0]), 32'h1);
      step();
      chk("g_pend3", 32'(div_pending), 32'h0);
      chk("g_tick2", 32'(tick[0]), 32'h1);
      seq("d6", 0, 6, 16'b001110, 16'b000001);

      // reset mid-pending discards the write
      wr(1, 9);
      chk("h_pend", 32'(div_pending), 32'h2);
      #2 reset_n = 1'b0;
      #1;
      chk("h_rst_pend", 32'(div_pending), 32'h0);
      chk("h_rst_clk", 32'(clock_out), 32'h0);
      chk("h_rst_tick", 32'(tick), 32'h0);
      step();
      reset_n = 1'b1;
      seq("h_d4", 1, 4, 16'b0110, 16'b0001);
      chk("h_pend2", 32'(div_pending), 32'h0);

`ifdef CLKDIV_SYNC_EN
      wr(0, 3);
      repeat (6) step();
      wr(0, 4);
      chk("s_pend1", 32'(div_pending), 32'h1);
      sync_n = 1'b0;
      step();
      sync_n = 1'b1;
      chk("s_clk", 32'(clock_out), 32'h0);
      chk("s_tick", 32'(tick), 32'h0);
      chk("s_pend2", 32'(div_pending), 32'h0);
      seq("s_d4", 0, 4, 16'b0110, 16'b0001);
      chk("s_both", 32'(tick), 32'h3);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
